// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: sequential PC generation, credit-limited word
// fetches, in-order response buffer to decode, redirect and fault handling.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_fetch_exception,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding, discard, out_nxt;
    entry_t        fifo [DEPTH];
    entry_t        head, push_entry;
    logic [AW:0]   wr_ptr, rd_ptr, occ;
    logic [31:0]   pcq [DEPTH];
    logic [AW-1:0] pq_wr, pq_rd;
    logic [SW-1:0] credit_use;
    logic          pop, grant, full, aligned, rsp_push, mis_push, push;

    assign occ        = wr_ptr - rd_ptr;
    assign full       = (occ == (AW+1)'(DEPTH));
    assign o_valid    = (occ != '0);
    assign pop        = o_valid & i_ready;
    assign aligned    = (fetch_pc[1:0] == 2'b00);

    // Outstanding fetches plus buffered entries must leave room for every reply.
    assign credit_use  = SW'(outstanding) + SW'(occ) - SW'(pop);
    assign o_imem_req  = ~i_rst & (state == RUN) & aligned & (credit_use < SW'(DEPTH)) & ~i_redirect;
    assign o_imem_addr = fetch_pc;
    assign grant       = o_imem_req & i_imem_gnt;
    assign out_nxt     = outstanding + CW'(grant) - CW'(i_imem_rvalid);

    assign rsp_push = i_imem_rvalid & (discard == '0) & ~i_redirect & (state == RUN);
    assign mis_push = (state == RUN) & ~aligned & (outstanding == '0) & ~full & ~i_redirect;
    assign push     = rsp_push | mis_push;

    always_comb begin
        push_entry = '{instr: NOP, pc: fetch_pc, exc: 1'b1};
        if (!mis_push) begin
            push_entry.instr = i_imem_err ? NOP : i_imem_rdata;
            push_entry.pc    = pcq[pq_rd];
            push_entry.exc   = i_imem_err;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_redirect)
            state_nxt = RUN;
        else if ((rsp_push & i_imem_err) | mis_push)
            state_nxt = HALT;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= RUN;
        else       state <= state_nxt;
    end

    // PC-of-request queue: one slot per outstanding fetch, dropped replies pop too.
    always_ff @(posedge i_clk) begin
        if (grant) pcq[pq_wr] <= fetch_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pq_wr       <= '0;
            pq_rd       <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '{instr: NOP, pc: RESET_PC, exc: 1'b0};
        end else begin
            outstanding <= out_nxt;
            if (grant)         pq_wr <= pq_wr + 1'b1;
            if (i_imem_rvalid) pq_rd <= pq_rd + 1'b1;
            if (i_redirect) begin
                fetch_pc <= i_redirect_pc;
                discard  <= out_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (i_imem_rvalid && discard != '0)
                    discard <= discard - 1'b1;
                else if (rsp_push && i_imem_err)
                    discard <= out_nxt;
                if (push) begin
                    fifo[wr_ptr[AW-1:0]] <= push_entry;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head              = fifo[rd_ptr[AW-1:0]];
    assign o_instr           = head.instr;
    assign o_pc              = head.pc;
    assign o_fetch_exception = head.exc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order instruction memory model.
module tb_ifetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_fetch_exception;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    logic        mem_stall;
    logic [31:0] err_addr;
    logic [31:0] mq [$];
    logic [31:0] mem_a;

    ifetch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .i_imem_err(i_imem_err),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_fetch_exception(o_fetch_exception),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    // Memory word at address a is a ^ 0xDEAD0000; replies one cycle after grant
    // unless stalled, in grant order.
    always @(posedge i_clk) begin
        if (i_rst) begin
            mq.delete();
            i_imem_rvalid <= 1'b0;
            i_imem_err    <= 1'b0;
            i_imem_rdata  <= '0;
        end else begin
            if (o_imem_req && i_imem_gnt) mq.push_back(o_imem_addr);
            i_imem_rvalid <= 1'b0;
            i_imem_err    <= 1'b0;
            if (!mem_stall && mq.size() > 0) begin
                mem_a = mq.pop_front();
                i_imem_rvalid <= 1'b1;
                i_imem_rdata  <= mem_a ^ 32'hDEAD_0000;
                i_imem_err    <= (mem_a == err_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        logic        exp_ex [3];
        int          n, k;
        logic        anyreq;

        i_rst = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b1; i_redirect = 1'b0;
        i_redirect_pc = '0; mem_stall = 1'b0; err_addr = 32'hFFFF_FFFF;

        // Reset values
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_req",   o_imem_req, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_instr", o_instr, 32'h13);
        chk("rst_pc",    o_pc, 0);
        chk("rst_exc",   o_fetch_exception, 0);

        // Sequential fetch, one per cycle
        @(negedge i_clk); i_rst = 1'b0; #1;
        chk("c1_req",  o_imem_req, 1);
        chk("c1_addr", o_imem_addr, 32'h0);
        nxt();
        chk("c2_addr",  o_imem_addr, 32'h4);
        chk("c2_valid", o_valid, 0);
        nxt();
        chk("c3_valid", o_valid, 1);
        chk("c3_pc",    o_pc, 32'h0);
        chk("c3_instr", o_instr, 32'hDEAD_0000);
        chk("c3_addr",  o_imem_addr, 32'h8);
        nxt();
        chk("c4_pc",    o_pc, 32'h4);
        chk("c4_instr", o_instr, 32'hDEAD_0004);
        nxt();
        chk("c5_valid", o_valid, 1);
        chk("c5_pc",    o_pc, 32'h8);

        // Decode backpressure: buffer fills, requests stop, nothing lost
        @(negedge i_clk); i_ready = 1'b0;
        repeat (10) @(negedge i_clk);
        #1;
        chk("bp_valid", o_valid, 1);
        chk("bp_pc",    o_pc, 32'hC);
        chk("bp_req",   o_imem_req, 0);
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rel_valid", o_valid, 1);
            chk("rel_pc",    o_pc, 32'hC + 32'(4 * i));
            nxt();
        end

        // Redirect with two fetches in flight
        mem_stall = 1'b1;
        repeat (6) nxt();
        chk("inflight_valid", o_valid, 0);
        chk("inflight_req",   o_imem_req, 0);
        i_redirect = 1'b1; i_redirect_pc = 32'h100;
        @(negedge i_clk); i_redirect = 1'b0; mem_stall = 1'b0; #1;
        chk("rd1_valid", o_valid, 0);
        chk("rd1_addr",  o_imem_addr, 32'h100);
        n = 0;
        while (!o_valid && n < 20) begin nxt(); n++; end
        chk("rd1_seen",  o_valid, 1);
        chk("rd1_pc",    o_pc, 32'h100);
        chk("rd1_instr", o_instr, 32'hDEAD_0100);
        chk("rd1_exc",   o_fetch_exception, 0);

        // Redirect to a misaligned PC
        i_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h102;
        @(negedge i_clk); i_redirect = 1'b0; #1;
        chk("mis_valid0", o_valid, 0);
        anyreq = o_imem_req;
        n = 0;
        while (!o_valid && n < 20) begin nxt(); anyreq |= o_imem_req; n++; end
        chk("mis_seen",  o_valid, 1);
        chk("mis_pc",    o_pc, 32'h102);
        chk("mis_instr", o_instr, 32'h13);
        chk("mis_exc",   o_fetch_exception, 1);
        chk("mis_noreq", anyreq, 0);
        i_ready = 1'b1;
        repeat (4) nxt();
        chk("halt_valid", o_valid, 0);
        chk("halt_req",   o_imem_req, 0);
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        @(negedge i_clk); i_redirect = 1'b0; #1;
        chk("res_req",  o_imem_req, 1);
        chk("res_addr", o_imem_addr, 32'h200);

        // Memory error on 0x8; later in-flight reply dropped, fetch halts
        nxt();
        err_addr = 32'h8;
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_in = '{32'hDEAD_0000, 32'hDEAD_0004, 32'h13};
        exp_ex = '{1'b0, 1'b0, 1'b1};
        i_redirect = 1'b1; i_redirect_pc = 32'h0;
        @(negedge i_clk); i_redirect = 1'b0; #1;
        k = 0;
        for (int c = 0; c < 15; c++) begin
            if (o_valid) begin
                if (k < 3) begin
                    chk("err_pc",    o_pc, exp_pc[k]);
                    chk("err_instr", o_instr, exp_in[k]);
                    chk("err_exc",   o_fetch_exception, exp_ex[k]);
                end
                k++;
            end
            nxt();
        end
        chk("err_count", 32'(k), 3);
        chk("err_req",   o_imem_req, 0);
        chk("err_valid", o_valid, 0);

        // Grant withheld: request held stable
        err_addr = 32'hFFFF_FFFF;
        i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h300;
        @(negedge i_clk); i_redirect = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("gnt_req",  o_imem_req, 1);
            chk("gnt_addr", o_imem_addr, 32'h300);
            nxt();
        end
        i_imem_gnt = 1'b1;
        chk("gnt_addr3", o_imem_addr, 32'h300);
        nxt();
        chk("gnt_next", o_imem_addr, 32'h304);

        // Reset pulse mid-stream
        nxt(); nxt();
        i_rst = 1'b1; #1;
        chk("rst2_req_comb", o_imem_req, 0);
        nxt();
        chk("rst2_valid", o_valid, 0);
        chk("rst2_instr", o_instr, 32'h13);
        chk("rst2_pc",    o_pc, 32'h0);
        chk("rst2_exc",   o_fetch_exception, 0);
        i_rst = 1'b0; #1;
        chk("rst2_req",  o_imem_req, 1);
        chk("rst2_addr", o_imem_addr, 32'h0);
        nxt();
        chk("rst2_addr4", o_imem_addr, 32'h4);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
